// File: rtl/pc_seq_if.sv
// Request/status bundle between the fetch control logic and the PC sequencer.
//   master: drives stall/branch/jump/call/ret/panic/eret requests and reads the status.
//   slave : the sequencer; it samples the requests and drives pc_out, epc_out, mode,
//           ras_count and ras_overflow.
interface pc_seq_if #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned BR_OFF_W  = 13,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

    logic                stall;
    logic                branch;
    logic [BR_OFF_W-1:0] branch_offset;
    logic                jump;
    logic                call;
    logic [ADDR_W-3:0]   jump_target;
    logic                ret;
    logic                panic;
    logic                eret;

    logic [ADDR_W-1:0]   pc_out;
    logic [ADDR_W-1:0]   epc_out;
    logic [1:0]          mode;
    logic [CNT_W-1:0]    ras_count;
    logic                ras_overflow;

    modport master (
        output stall, branch, branch_offset, jump, call, jump_target, ret, panic, eret,
        input  pc_out, epc_out, mode, ras_count, ras_overflow
    );

    modport slave (
        input  stall, branch, branch_offset, jump, call, jump_target, ret, panic, eret,
        output pc_out, epc_out, mode, ras_count, ras_overflow
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage: sequential/branch/jump advance,
// return-address stack for call/ret, and a RUN/HANDLER/HALT fault FSM with saved EPC.
// Ports:
//   clk     - clock, all state changes on the rising edge
//   reset_n - synchronous active-low reset
//   bus     - pc_seq_if slave: request inputs, registered PC/EPC/mode/RAS status outputs
module pc_sequencer #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned BR_OFF_W     = 13,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] PANIC_VECTOR = 32'h0FFF_FFF0,
    parameter int unsigned RAS_DEPTH    = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    pc_seq_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [ADDR_W-1:0] RST_PC   = ADDR_W'(RESET_VECTOR);
    localparam logic [ADDR_W-1:0] PANIC_PC = ADDR_W'(PANIC_VECTOR);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_HANDLER = 2'b01,
        ST_HALT    = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  sp_q, sp_d;
    logic              ovf_q, ovf_d;
    logic              push_c;
    logic              fault_c;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] off_ext;
    logic [ADDR_W-1:0] br_pc;
    logic [ADDR_W-1:0] tgt_pc;

    // Candidate next-PC values; all arithmetic wraps modulo 2^ADDR_W.
    assign seq_pc  = pc_q + ADDR_W'(4);
    assign off_ext = ADDR_W'($signed(bus.branch_offset));
    assign br_pc   = pc_q + {off_ext[ADDR_W-3:0], 2'b00};
    assign tgt_pc  = {bus.jump_target, 2'b00};

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            pc_q    <= RST_PC;
            epc_q   <= '0;
            cnt_q   <= '0;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            cnt_q   <= cnt_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
        end
    end

    // RAS storage; sp_q is the next write slot, so when full it points at the oldest entry.
    always_ff @(posedge clk) begin
        if (reset_n && push_c) begin
            ras_q[sp_q] <= seq_pc;
        end
    end

    // Request arbitration and fault FSM next-state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        cnt_d   = cnt_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        push_c  = 1'b0;
        fault_c = 1'b0;

        if (state_q == ST_RUN || state_q == ST_HANDLER) begin
            if (bus.panic) begin
                fault_c = 1'b1;
            end else if (bus.eret && state_q == ST_HANDLER) begin
                pc_d    = epc_q;
                state_d = ST_RUN;
            end else if (bus.branch) begin
                pc_d = br_pc;
            end else if (bus.call) begin
                push_c = 1'b1;
                pc_d   = tgt_pc;
                sp_d   = sp_q + PTR_W'(1);
                if (cnt_q == CNT_FULL) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (bus.jump) begin
                pc_d = tgt_pc;
            end else if (bus.ret) begin
                if (cnt_q != '0) begin
                    pc_d  = ras_q[sp_q - PTR_W'(1)];
                    sp_d  = sp_q - PTR_W'(1);
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Return-stack underflow behaves as a panic.
                    fault_c = 1'b1;
                end
            end else if (!bus.stall) begin
                pc_d = seq_pc;
            end

            if (fault_c) begin
                pc_d = PANIC_PC;
                if (state_q == ST_RUN) begin
                    epc_d   = pc_q;
                    state_d = ST_HANDLER;
                end else begin
                    state_d = ST_HALT;
                end
            end
        end
    end

    assign bus.pc_out       = pc_q;
    assign bus.epc_out      = epc_q;
    assign bus.mode         = 2'(state_q);
    assign bus.ras_count    = cnt_q;
    assign bus.ras_overflow = ovf_q;
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the fetch stage. It generalises the single-cycle PC register: configurable address width, branch-offset width and reset/panic vectors, plus a stall input and signed branch offsets. It adds a return-address stack (RAS) for call/return and a three-state fault FSM with a saved exception PC (EPC) and return-from-handler. Its registered PC drives instruction-memory addressing.

## Interface
- ADDR_W, 32, PC width in bits (≥ 8)
- BR_OFF_W, 13, branch offset width in words, signed
- RESET_VECTOR, 0, PC value loaded by reset
- PANIC_VECTOR, 32'h0FFFFFF0, handler entry address, truncated to ADDR_W
- RAS_DEPTH, 4, return-stack entries (power of two, ≥ 2)
- clk  input  1  clock, all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset
- stall  input  1  freeze sequential advance
- branch  input  1  PC-relative redirect
- branch_offset  input  BR_OFF_W  signed word offset
- jump  input  1  absolute redirect
- call  input  1  absolute redirect plus push of return address
- jump_target  input  ADDR_W-2  word address for jump and call
- ret  input  1  pop the RAS and redirect to the popped address
- panic  input  1  fault request
- eret  input  1  return from handler
- pc_out  output  ADDR_W  current PC
- epc_out  output  ADDR_W  saved faulting PC
- mode  output  2  00 RUN, 01 HANDLER, 10 HALT
- ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries
- ras_overflow  output  1  sticky: a call overwrote the oldest entry

## Operation
- Reset, sampled on the clock edge while reset_n=0, loads these values:
  - pc_out=RESET_VECTOR
  - epc_out=0
  - mode=RUN
  - ras_count=0
  - ras_overflow=0
  - RAS contents are don't-care.
- Request priority, highest first: panic > eret > branch > call > jump > ret > stall > sequential.
  - Only the winning request takes effect.
  - Losing requests have no side effects; in particular they cause no RAS push or pop.
- Arithmetic is modulo 2^ADDR_W, with wrap-around and no flag.
  - Sequential: pc+4.
  - Branch: pc + (sign_ext(branch_offset) << 2).
  - Jump and call: {jump_target, 2'b00}.
- Redirects (panic, eret, branch, call, jump, ret) override stall. stall only suppresses the +4 advance.
- call:
  - Pushes pc+4, then PC ← target.
  - When full, the write overwrites the oldest entry (circular buffer), ras_count stays at RAS_DEPTH, and ras_overflow is set.
- ret:
  - With ras_count>0: PC ← top entry, ras_count decrements.
  - With ras_count=0: treated exactly as a panic (ret underflow).
- FSM transitions:
  - RUN + panic: epc ← pc_out, PC ← PANIC_VECTOR, mode → HANDLER.
  - HANDLER + eret: PC ← epc, mode → RUN. epc is unchanged.
  - HANDLER + panic (double fault): PC ← PANIC_VECTOR, mode → HALT. epc is unchanged.
  - RUN + eret: ignored. The next-lower request is evaluated.
  - HALT: all state frozen, every input ignored. Only reset leaves HALT.
- The RAS is shared across RUN and HANDLER and is not cleared on panic or eret.
- ras_overflow clears only on reset.

## Timing
- Single-cycle latency: requests are sampled on the rising edge, and the new pc_out is valid right after that edge.
- All outputs are registered; there is no combinational input-to-output path.
- A reset asserted mid-operation overrides every concurrent request in the same edge.
- A push and a pop never occur in the same cycle (priority guarantees this).
- A call with ras_count=RAS_DEPTH-1 makes the stack full without overflow. The next call sets ras_overflow.
- The internal panic raised by ret underflow follows the same per-mode rules as external panic, so an underflow in HANDLER goes to HALT.

## Test plan
- Reset and sequencing, RESET_VECTOR=0: release reset, then 3 idle cycles → pc_out 0,4,8,12. Set stall=1 for 2 cycles → pc_out holds 12.
- Signed branch at pc=0x100:
  - branch_offset=-4 (13'h1FFC) → 0xF0.
  - Then branch_offset=+8 → 0x110.
  - At pc=0xFFFFFFFC, sequential step → 0 (wrap).
- Priority: branch, call and stall asserted together at pc=0x40, offset=2 → pc=0x48, ras_count stays 0.
- RAS with RAS_DEPTH=4:
  - 5 calls from pcs 0x10, 0x20, 0x30, 0x40, 0x50 → ras_count=4, ras_overflow=1.
  - 4 rets → pcs 0x54, 0x44, 0x34, 0x24.
  - 5th ret → mode=HANDLER, pc=PANIC_VECTOR, epc=pc at the ret.
- Fault FSM:
  - panic at pc=0x200 → pc=0x0FFFFFF0, epc=0x200, mode=01.
  - eret → pc=0x200, mode=00.
  - panic, then panic again → mode=10, pc frozen for 10 cycles despite stimuli.
  - reset_n=0 for one edge → pc=0, mode=00.
- Reset mid-call: reset_n=0 in the same cycle as call, with ras_count=2 → ras_count=0, pc=RESET_VECTOR.
